// File: rtl/axi_wr_arb.sv
// rtl/axi_wr_arb.sv - two-requester round-robin AXI write arbiter, fixed 16-beat bursts
// Optional watchdog: define AXI_WR_ARB_TIMEOUT_EN to enable the sticky timeout flag.
module axi_wr_arb #(
    parameter int TO_CYCLES = 256
) (
    input  logic        AXI_clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [63:0] addr,
    input  logic [63:0] data,
    output logic [1:0]  next,
    output logic [1:0]  done,
    output logic [31:0] AXI_awaddr,
    output logic        AXI_awvalid,
    input  logic        AXI_awready,
    output logic [31:0] AXI_wdata,
    output logic        AXI_wvalid,
    output logic        AXI_wlast,
    input  logic        AXI_wready,
    input  logic        AXI_bvalid,
    input  logic [1:0]  AXI_bresp,
    output logic        busy,
    output logic        err,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state_q;
    logic        grant_q;
    logic        grant_d;
    logic        last_q;
    logic [3:0]  beat_q;
    logic [31:0] awaddr_q;
    logic        err_q;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;

    assign aw_hs = (state_q == ADDR) && AXI_awready;
    assign w_hs  = (state_q == DATA) && AXI_wready;
    assign b_hs  = (state_q == RESP) && AXI_bvalid;

    // On a tie, the requester that did not win last time gets the bus.
    always_comb begin
        grant_d = 1'b0;
        if (req == 2'b11) grant_d = ~last_q;
        else              grant_d = req[1];
    end

    always_ff @(posedge AXI_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            beat_q   <= 4'd0;
            awaddr_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|req) begin
                    grant_q  <= grant_d;
                    last_q   <= grant_d;
                    awaddr_q <= grant_d ? addr[63:32] : addr[31:0];
                    state_q  <= ADDR;
                end
                ADDR: if (AXI_awready) begin
                    beat_q  <= 4'd0;
                    state_q <= DATA;
                end
                DATA: if (AXI_wready) begin
                    beat_q <= beat_q + 4'd1;
                    if (beat_q == 4'd15) state_q <= RESP;
                end
                RESP: if (AXI_bvalid) begin
                    if (AXI_bresp != 2'b00) err_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign err         = err_q;
    assign AXI_awaddr  = awaddr_q;
    assign AXI_awvalid = (state_q == ADDR);
    assign AXI_wvalid  = (state_q == DATA);
    assign AXI_wlast   = (state_q == DATA) && (beat_q == 4'd15);
    assign AXI_wdata   = (state_q != DATA) ? 32'd0 : (grant_q ? data[63:32] : data[31:0]);
    assign next        = {w_hs & grant_q, w_hs & ~grant_q};
    assign done        = {b_hs & grant_q, b_hs & ~grant_q};

`ifdef AXI_WR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);
    localparam logic [CW-1:0] TO_MAX  = CW'(TO_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

    logic [CW-1:0] to_cnt_q;
    logic          timeout_q;

    // Counts consecutive stalled cycles; any handshake or return to IDLE restarts it.
    always_ff @(posedge AXI_clk) begin
        if (rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (busy && !(aw_hs || w_hs || b_hs)) begin
            if (to_cnt_q != TO_MAX) to_cnt_q <= to_cnt_q + 1'b1;
            if (to_cnt_q == TO_LAST) timeout_q <= 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end

    assign timeout = timeout_q;
`else
    // Watchdog absent: the comparison is constant false, keeping the flag tied low.
    assign timeout = (TO_CYCLES < 0);
`endif

endmodule

// File: tb/tb_axi_wr_arb.sv
// tb/tb_axi_wr_arb.sv - directed table-driven bench for axi_wr_arb
module tb_axi_wr_arb;

    logic        AXI_clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  next;
    logic [1:0]  done;
    logic [31:0] AXI_awaddr;
    logic        AXI_awvalid;
    logic        AXI_awready;
    logic [31:0] AXI_wdata;
    logic        AXI_wvalid;
    logic        AXI_wlast;
    logic        AXI_wready;
    logic        AXI_bvalid;
    logic [1:0]  AXI_bresp;
    logic        busy;
    logic        err;
    logic        timeout;

    logic [31:0] cnt0 = 32'd0;
    logic [31:0] cnt1 = 32'd0;

    int errs = 0;
    int checks = 0;

    always #5 AXI_clk = ~AXI_clk;

    assign addr = {32'h2000_0040, 32'h1000_0040};
    assign data = {32'hB000_0000 + cnt1, 32'hA000_0000 + cnt0};

    axi_wr_arb #(.TO_CYCLES(256)) dut (
        .AXI_clk(AXI_clk), .rst(rst), .req(req), .addr(addr), .data(data),
        .next(next), .done(done),
        .AXI_awaddr(AXI_awaddr), .AXI_awvalid(AXI_awvalid), .AXI_awready(AXI_awready),
        .AXI_wdata(AXI_wdata), .AXI_wvalid(AXI_wvalid), .AXI_wlast(AXI_wlast),
        .AXI_wready(AXI_wready), .AXI_bvalid(AXI_bvalid), .AXI_bresp(AXI_bresp),
        .busy(busy), .err(err), .timeout(timeout)
    );

    typedef struct {
        logic [1:0] req;
        logic [1:0] bresp;
        bit         tog;
        int         g;
        bit         err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_awvalid"}, AXI_awvalid, 0);
        chk({tag, "_wvalid"}, AXI_wvalid, 0);
        chk({tag, "_wlast"}, AXI_wlast, 0);
        chk({tag, "_next"}, next, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_awaddr"}, AXI_awaddr, 0);
        chk({tag, "_wdata"}, AXI_wdata, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the burst ends.
    task automatic run_burst(input vec_t v);
        int aw = 0;
        int nb = 0;
        int cyc = 0;
        bit got_done = 0;
        bit wr;
        bit p0, p1;
        req = v.req;
        AXI_bresp = v.bresp;
        AXI_awready = 1'b1;
        AXI_bvalid = 1'b1;
        wr = v.tog ? 1'b0 : 1'b1;
        AXI_wready = wr;
        while (!got_done && cyc < 200) begin
            @(negedge AXI_clk);
            cyc++;
            if (AXI_awvalid) begin
                aw++;
                chk("awaddr", AXI_awaddr, v.g ? 32'h2000_0040 : 32'h1000_0040);
            end
            if (AXI_wvalid)
                chk("wdata", AXI_wdata, v.g ? 32'hB000_0000 + cnt1 : 32'hA000_0000 + cnt0);
            if (next != 2'b00) begin
                chk("next_bit", next, 2'b01 << v.g);
                chk("wlast", AXI_wlast, nb == 15);
                nb++;
            end
            if (done != 2'b00) begin
                chk("done_bit", done, 2'b01 << v.g);
                got_done = 1;
            end
            p0 = next[0];
            p1 = next[1];
            @(posedge AXI_clk);
            #1;
            if (p0) cnt0++;
            if (p1) cnt1++;
            if (v.tog) begin
                wr = ~wr;
                AXI_wready = wr;
            end
        end
        chk("burst_done", got_done, 1);
        chk("aw_cycles", aw, 1);
        chk("beats", nb, 16);
        @(negedge AXI_clk);
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
        chk("err", err, v.err);
    endtask

    initial begin
        vec_t tie;
        int n;
        int cyc;
        bit p0;

        vecs[0] = '{req: 2'b01, bresp: 2'b00, tog: 0, g: 0, err: 0};
        vecs[1] = '{req: 2'b11, bresp: 2'b00, tog: 0, g: 1, err: 0};
        vecs[2] = '{req: 2'b11, bresp: 2'b00, tog: 0, g: 0, err: 0};
        vecs[3] = '{req: 2'b11, bresp: 2'b00, tog: 0, g: 1, err: 0};
        vecs[4] = '{req: 2'b11, bresp: 2'b10, tog: 0, g: 0, err: 1};
        vecs[5] = '{req: 2'b10, bresp: 2'b00, tog: 1, g: 1, err: 1};
        vecs[6] = '{req: 2'b01, bresp: 2'b00, tog: 1, g: 0, err: 1};

        rst = 1'b1;
        req = 2'b00;
        AXI_awready = 1'b0;
        AXI_wready = 1'b0;
        AXI_bvalid = 1'b0;
        AXI_bresp = 2'b00;
        repeat (2) @(posedge AXI_clk);
        @(negedge AXI_clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_burst(vecs[i]);

        // Reset once the beat counter reaches 7.
        req = 2'b01;
        AXI_awready = 1'b1;
        AXI_wready = 1'b1;
        AXI_bvalid = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 7 && cyc < 100) begin
            @(negedge AXI_clk);
            cyc++;
            p0 = next[0];
            if (next != 2'b00) n++;
            @(posedge AXI_clk);
            #1;
            if (p0) cnt0++;
        end
        chk("pre_reset_beats", n, 7);
        rst = 1'b1;
        AXI_wready = 1'b0;
        @(negedge AXI_clk);
        chk("pre_reset_busy", busy, 1);
        @(negedge AXI_clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        req = 2'b00;
        AXI_wready = 1'b1;
        repeat (3) begin
            @(negedge AXI_clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end

        tie = '{req: 2'b11, bresp: 2'b00, tog: 0, g: 0, err: 0};
        run_burst(tie);
        req = 2'b00;

`ifdef AXI_WR_ARB_TIMEOUT_EN
        req = 2'b01;
        AXI_awready = 1'b0;
        @(posedge AXI_clk);
        #1;
        req = 2'b00;
        repeat (255) @(posedge AXI_clk);
        @(negedge AXI_clk);
        chk("timeout_255", timeout, 0);
        chk("stall_awvalid", AXI_awvalid, 1);
        @(negedge AXI_clk);
        chk("timeout_256", timeout, 1);
        chk("timeout_state_kept", AXI_awvalid, 1);
`else
        req = 2'b01;
        AXI_awready = 1'b0;
        repeat (300) @(posedge AXI_clk);
        @(negedge AXI_clk);
        chk("stall_awvalid", AXI_awvalid, 1);
        chk("timeout_tied", timeout, 0);
`endif
        rst = 1'b1;
        @(negedge AXI_clk);
        rst = 1'b0;
        req = 2'b00;
        chk("timeout_cleared", timeout, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
